// File: rtl/serial_add_ctrl_if.sv
// rtl/serial_add_ctrl_if.sv - request/result bundle for serial_add_ctrl (sub only with SERIAL_ADD_SUB_EN)
interface serial_add_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
`ifdef SERIAL_ADD_SUB_EN
    output sub,
`endif
    output start, op_a, op_b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
`ifdef SERIAL_ADD_SUB_EN
    input  sub,
`endif
    input  start, op_a, op_b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder using one shared full-adder cell, LSB first
// Optional subtract mode (sub port) is enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  serial_add_ctrl_if.slave   bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry_reg;
  logic             cout_reg;
  logic [CW-1:0]    cnt;

  logic             cell_s;
  logic             cell_co;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] v, input logic b);
    logic [WIDTH-1:0] r;
    r = v >> 1;
    r[WIDTH-1] = b;
    return r;
  endfunction

  always_comb begin
    cell_s  = a_sr[0] ^ b_sr[0] ^ carry_reg;
    cell_co = (a_sr[0] & b_sr[0]) | (carry_reg & (a_sr[0] ^ b_sr[0]));
  end

  // Subtraction is A + ~B + 1, so only the B load and the initial carry differ.
  always_comb begin
`ifdef SERIAL_ADD_SUB_EN
    b_load = bus.sub ? ~bus.op_b : bus.op_b;
    c_load = bus.sub ? 1'b1 : bus.cin;
`else
    b_load = bus.op_b;
    c_load = bus.cin;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      sum_sr    <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sr      <= bus.op_a;
            b_sr      <= b_load;
            carry_reg <= c_load;
            cnt       <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          sum_sr    <= shift_in(sum_sr, cell_s);
          a_sr      <= a_sr >> 1;
          b_sr      <= b_sr >> 1;
          carry_reg <= cell_co;
          cnt       <= cnt + CW'(1);
          if (cnt == LAST) begin
            cout_reg <= cell_co;
            state    <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_sr;
  assign bus.cout = cout_reg;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl against an arithmetic model
module tb_serial_add_ctrl;
  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH:0] ref_result(input int a, input int b, input int c, input int s);
    int r;
    if (s != 0) r = a + (1 << WIDTH) - b;
    else        r = a + b + c;
    return r[WIDTH:0];
  endfunction

  task automatic drive_ops(input int a, input int b, input int c, input int s);
    bus.op_a = WIDTH'(a);
    bus.op_b = WIDTH'(b);
    bus.cin  = c[0];
`ifdef SERIAL_ADD_SUB_EN
    bus.sub  = s[0];
`endif
  endtask

  // Accepts an op, scrambles inputs while it runs, checks timing; ends in cycle T+6 (IDLE).
  task automatic run_op(input int a, input int b, input int c, input int s, output logic [WIDTH:0] got);
    drive_ops(a, b, c, s);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    got = 'x;
    for (int k = 1; k <= 6; k++) begin
      drive_ops($urandom, $urandom, $urandom, $urandom);
      check($sformatf("busy_k%0d", k), bus.busy, (k <= 5));
      check($sformatf("done_k%0d", k), bus.done, (k == 5));
      if (k == 5) got = {bus.cout, bus.sum};
      if (k == 6) check("held", {bus.cout, bus.sum}, got);
      if (k < 6) tick();
    end
    drive_ops(0, 0, 0, 0);
  endtask

  initial begin
    logic [WIDTH:0] got;
    int a, b, c;

    rst = 1'b1;
    bus.start = 1'b0;
    drive_ops(0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_sum",  bus.sum,  0);
    check("rst_cout", bus.cout, 0);

    run_op(5, 3, 0, 0, got);
    check("add_5_3", got, 5'b01000);
    run_op(15, 1, 0, 0, got);
    check("add_15_1", got, 5'b10000);
    run_op(0, 0, 1, 0, got);
    check("add_0_0_c1", got, 5'b00001);

    // start held through RUN/DONE; operands switch to all-ones after acceptance
    drive_ops(5, 3, 0, 0);
    bus.start = 1'b1;
    tick();
    drive_ops(15, 15, 0, 0);
    for (int k = 1; k <= 11; k++) begin
      check($sformatf("hold_done_k%0d", k), bus.done, (k == 5 || k == 11));
      check($sformatf("hold_busy_k%0d", k), bus.busy, (k != 6));
      if (k == 5)  check("hold_first",  {bus.cout, bus.sum}, ref_result(5, 3, 0, 0));
      if (k == 11) check("hold_second", {bus.cout, bus.sum}, 5'b11110);
      tick();
    end
    bus.start = 1'b0;
    tick();

    // reset in the middle of an add
    drive_ops(5, 3, 0, 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_sum",  bus.sum,  0);
    check("mid_rst_cout", bus.cout, 0);
    for (int k = 0; k < 4; k++) begin
      check("mid_rst_no_done", bus.done, 0);
      tick();
    end
    run_op(5, 3, 0, 0, got);
    check("after_rst_add", got, 5'b01000);

    for (int s = 0; s < 16 * 16 * 2; s++) begin
      a = s % 16;
      b = (s / 16) % 16;
      c = s / 256;
      run_op(a, b, c, 0, got);
      check($sformatf("sweep_%0d_%0d_%0d", a, b, c), got, ref_result(a, b, c, 0));
    end

    for (int n = 0; n < 40; n++) begin
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 15));
      c = int'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) tick();
      run_op(a, b, c, 0, got);
      check($sformatf("rand_%0d_%0d_%0d", a, b, c), got, ref_result(a, b, c, 0));
    end

`ifdef SERIAL_ADD_SUB_EN
    run_op(5, 3, 0, 1, got);
    check("sub_5_3", got, 5'b10010);
    run_op(3, 5, 1, 1, got);
    check("sub_3_5", got, 5'b01110);
    for (int n = 0; n < 40; n++) begin
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 15));
      c = int'($urandom_range(0, 1));
      run_op(a, b, c, 1, got);
      check($sformatf("rsub_%0d_%0d", a, b), got, ref_result(a, b, c, 1));
      check("rsub_borrow", got[WIDTH], (a >= b));
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
